t2mi_stream_selector: RTL and testbench
=======================================

T2MI_STREAM_SELECTOR -- requirements
Module: t2mi_stream_selector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000000; source inactivity and resync limit in clk cycles (10 ms at 100 MHz).
REQ-002 SHALL have parameter AUTO_FALLBACK, default 1; 1 enables automatic CAM-to-direct fallback.
REQ-003 SHALL have port clk, input, 1; system clock. All logic is in this one clock domain.
REQ-004 SHALL have port rst, input, 1; reset, asynchronous, active-high.
REQ-005 SHALL have port cam_bypass, input, 1; 1 requests the direct source, 0 requests the CAM source.
REQ-006 SHALL have port cam_ready, input, 1; CAM ready status from the CI receiver.
REQ-007 SHALL have ports direct_data, direct_valid and direct_sync, inputs, widths 8/1/1; direct T2-MI byte stream, pre-synchronised to clk.
REQ-008 SHALL have ports cam_data, cam_valid and cam_sync, inputs, widths 8/1/1; decrypted CAM stream from the CI receiver.
REQ-009 SHALL have ports out_data, out_valid and out_sync, outputs, widths 8/1/1; selected stream to the T2-MI packet parser.
REQ-010 SHALL have port active_src, output, 1; 1 = direct is forwarded, 0 = CAM is forwarded.
REQ-011 SHALL have port switching, output, 1; high while in WAIT_SYNC.
REQ-012 SHALL have ports direct_alive and cam_alive, outputs, 1 each; source activity flags.
REQ-013 SHALL have port resync_timeout, output, 1; WAIT_SYNC has lasted TIMEOUT_CYCLES or more.

Function
REQ-014 SHALL define target = DIRECT when cam_bypass=1; when AUTO_FALLBACK=1 and (cam_alive=0 or cam_ready=0); otherwise CAM.
REQ-015 SHALL implement FSM states FWD_DIRECT, FWD_CAM and WAIT_SYNC.
REQ-016 In FWD_x, a valid byte on source x SHALL appear on out_* registered, with exactly 1 cycle latency; out_valid=0 in cycles with no source-x valid.
REQ-017 In FWD_x, target≠x SHALL cause entry to WAIT_SYNC on the next cycle; mid-packet truncation is allowed, because the parser resynchronises.
REQ-018 In WAIT_SYNC, out_valid SHALL be 0 until target presents valid=1 with sync=1.
REQ-019 That sync byte SHALL be forwarded with out_sync=1, and the state SHALL become FWD_target in the same cycle.
REQ-020 If target changes during WAIT_SYNC, the block SHALL retarget immediately and restart the wait counter.
REQ-021 active_src SHALL update only on entry to FWD_x, and SHALL hold its previous value during WAIT_SYNC.
REQ-022 Each source SHALL have an activity counter: cleared on valid, incremented otherwise, saturating at TIMEOUT_CYCLES.
REQ-023 alive SHALL equal (counter < TIMEOUT_CYCLES).
REQ-024 The wait counter SHALL be cleared on entry to WAIT_SYNC and saturate at TIMEOUT_CYCLES.
REQ-025 resync_timeout SHALL equal (state=WAIT_SYNC and wait counter = TIMEOUT_CYCLES); the block SHALL remain in WAIT_SYNC while it is asserted.
REQ-026 A byte on the non-target source SHALL never reach out_*, including when it is simultaneous with the target's sync byte.
REQ-027 Counter widths SHALL be $clog2(TIMEOUT_CYCLES+1), and no counter SHALL wrap.

Reset
REQ-028 rst=1 SHALL force: state=WAIT_SYNC, active_src=1, out_data=0, out_valid=0, out_sync=0.
REQ-029 rst=1 SHALL also force: activity counters=TIMEOUT_CYCLES (alive=0), and wait counter=0.
REQ-030 Reset asserted mid-packet SHALL drop the packet; after release, forwarding SHALL resume only at the next target sync byte.

Structure
REQ-031 Package t2mi_pkg SHALL hold the source select constants (SRC_DIRECT=1, SRC_CAM=0) and the FSM state typedef.
REQ-032 Sub-module t2mi_activity_monitor (parameter TIMEOUT_CYCLES; ports clk, rst, valid, alive) SHALL implement REQ-022/023 and be instantiated once per source.

Verification
REQ-033 Release reset with cam_bypass=1, and direct bytes 0x47 (sync), 0x01 and 0x02 on consecutive cycles. Required: out_* carries the same bytes 1 cycle later, out_sync only on 0x47, and active_src=1.
REQ-034 Forward direct, cam_ready=1 with CAM active, then set cam_bypass=0 mid-packet. Required: switching=1 and out_valid=0 until the first CAM sync byte, which is forwarded with out_sync=1; then active_src=0.
REQ-035 Use TIMEOUT_CYCLES=16 and forward CAM, then stop cam_valid. Required: cam_alive falls 16 cycles after the last valid, WAIT_SYNC is entered, and forwarding resumes at the next direct sync.
REQ-036 Use TIMEOUT_CYCLES=16 and a WAIT_SYNC target with no sync bytes. Required: resync_timeout=1 after 16 cycles and cleared on the next target sync byte.
REQ-037 During WAIT_SYNC, drive a CAM sync byte and a direct sync byte in the same cycle with target=direct. Required: only the direct byte appears on out_*.
REQ-038 Assert rst for 1 cycle mid-packet. Required: all outputs are at reset values in the same cycle, and out_valid=0 until the next sync byte.

Source files
------------

// File: rtl/t2mi_pkg.sv
// Shared source-select constants and FSM state type for the T2-MI stream selector.
package t2mi_pkg;

    localparam logic SRC_DIRECT = 1'b1;
    localparam logic SRC_CAM    = 1'b0;

    typedef enum logic [1:0] {
        FWD_DIRECT = 2'd0,
        FWD_CAM    = 2'd1,
        WAIT_SYNC  = 2'd2
    } state_t;

    function automatic state_t fwd_state(input logic src);
        return (src == SRC_DIRECT) ? FWD_DIRECT : FWD_CAM;
    endfunction

endpackage

// File: rtl/t2mi_activity_monitor.sv
// Per-source inactivity counter: cleared on valid, saturates at TIMEOUT_CYCLES.
// alive drops once TIMEOUT_CYCLES consecutive cycles pass without a valid byte.
module t2mi_activity_monitor #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    output logic alive
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Reset to the limit so a source is considered dead until it proves otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= LIMIT;
        end else if (valid) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign alive = (cnt < LIMIT);

endmodule

// File: rtl/t2mi_stream_selector.sv
// Selects the direct or CAM T2-MI byte stream, switching only on a sync byte of the new source.
// Output is registered (1 cycle latency); the non-target source is always discarded.
module t2mi_stream_selector
    import t2mi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int AUTO_FALLBACK  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cam_bypass,
    input  logic       cam_ready,
    input  logic [7:0] direct_data,
    input  logic       direct_valid,
    input  logic       direct_sync,
    input  logic [7:0] cam_data,
    input  logic       cam_valid,
    input  logic       cam_sync,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sync,
    output logic       active_src,
    output logic       switching,
    output logic       direct_alive,
    output logic       cam_alive,
    output logic       resync_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    state_t        state, state_nxt;
    logic          wait_tgt, wait_tgt_nxt;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          active_nxt;
    logic          target;
    logic          fwd_src;
    logic          fwd;
    logic [7:0]    sel_data;
    logic          sel_valid;
    logic          sel_sync;

    t2mi_activity_monitor #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_direct_mon (
        .clk   (clk),
        .rst   (rst),
        .valid (direct_valid),
        .alive (direct_alive)
    );

    t2mi_activity_monitor #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cam_mon (
        .clk   (clk),
        .rst   (rst),
        .valid (cam_valid),
        .alive (cam_alive)
    );

    always_comb begin
        target = SRC_CAM;
        if (cam_bypass) begin
            target = SRC_DIRECT;
        end else if ((AUTO_FALLBACK != 0) && (!cam_alive || !cam_ready)) begin
            target = SRC_DIRECT;
        end
    end

    // Only the target source is ever looked at, so the other one cannot leak out.
    assign sel_data  = (target == SRC_DIRECT) ? direct_data  : cam_data;
    assign sel_valid = (target == SRC_DIRECT) ? direct_valid : cam_valid;
    assign sel_sync  = (target == SRC_DIRECT) ? direct_sync  : cam_sync;
    assign fwd_src   = (state == FWD_DIRECT) ? SRC_DIRECT : SRC_CAM;

    always_comb begin
        state_nxt    = state;
        wait_tgt_nxt = wait_tgt;
        wait_cnt_nxt = wait_cnt;
        active_nxt   = active_src;
        fwd          = 1'b0;
        case (state)
            FWD_DIRECT, FWD_CAM: begin
                if (target != fwd_src) begin
                    state_nxt    = WAIT_SYNC;
                    wait_tgt_nxt = target;
                    wait_cnt_nxt = '0;
                end else begin
                    fwd = sel_valid;
                end
            end
            default: begin
                if (target != wait_tgt) begin
                    wait_tgt_nxt = target;
                    wait_cnt_nxt = '0;
                end else if (sel_valid && sel_sync) begin
                    fwd        = 1'b1;
                    state_nxt  = fwd_state(target);
                    active_nxt = target;
                end else if (wait_cnt != LIMIT) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_SYNC;
            wait_tgt   <= SRC_DIRECT;
            wait_cnt   <= '0;
            active_src <= SRC_DIRECT;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sync   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_tgt   <= wait_tgt_nxt;
            wait_cnt   <= wait_cnt_nxt;
            active_src <= active_nxt;
            out_valid  <= fwd;
            out_sync   <= fwd & sel_sync;
            if (fwd) begin
                out_data <= sel_data;
            end
        end
    end

    assign switching      = (state == WAIT_SYNC);
    assign resync_timeout = (state == WAIT_SYNC) && (wait_cnt == LIMIT);

endmodule

// File: tb/tb_t2mi_stream_selector.sv
// Directed scoreboard bench for t2mi_stream_selector with a 16-cycle timeout.
module tb_t2mi_stream_selector;

    logic       clk;
    logic       rst;
    logic       cam_bypass;
    logic       cam_ready;
    logic [7:0] direct_data;
    logic       direct_valid;
    logic       direct_sync;
    logic [7:0] cam_data;
    logic       cam_valid;
    logic       cam_sync;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sync;
    logic       active_src;
    logic       switching;
    logic       direct_alive;
    logic       cam_alive;
    logic       resync_timeout;

    typedef struct {
        logic [7:0] data;
        logic       sync;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    t2mi_stream_selector #(
        .TIMEOUT_CYCLES (16),
        .AUTO_FALLBACK  (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cam_bypass     (cam_bypass),
        .cam_ready      (cam_ready),
        .direct_data    (direct_data),
        .direct_valid   (direct_valid),
        .direct_sync    (direct_sync),
        .cam_data       (cam_data),
        .cam_valid      (cam_valid),
        .cam_sync       (cam_sync),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_sync       (out_sync),
        .active_src     (active_src),
        .switching      (switching),
        .direct_alive   (direct_alive),
        .cam_alive      (cam_alive),
        .resync_timeout (resync_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Monitor: every output byte must match the head of the scoreboard, in content and timing.
    always @(negedge clk) begin
        if (out_valid) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL out_unexpected: got data=%h sync=%b at cyc %0d, expected no output",
                         out_data, out_sync, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data === e.data && out_sync === e.sync && cyc == e.cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL out_byte: got data=%h sync=%b cyc=%0d, expected data=%h sync=%b cyc=%0d",
                             out_data, out_sync, cyc, e.data, e.sync, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic dv, input logic [7:0] dd, input logic ds,
                       input logic cv, input logic [7:0] cd, input logic cs);
        direct_valid = dv; direct_data = dd; direct_sync = ds;
        cam_valid    = cv; cam_data    = cd; cam_sync    = cs;
    endtask

    task automatic expect_out(input logic [7:0] d, input logic s);
        sb.push_back('{data: d, sync: s, cyc: cyc + 1});
    endtask

    initial begin
        rst = 1'b1; cam_bypass = 1'b1; cam_ready = 1'b0;
        drv(0, 8'h00, 0, 0, 8'h00, 0);
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_active_src", 32'(active_src), 32'd1);
        chk("rst_switching", 32'(switching), 32'd1);
        chk("rst_alive", {30'd0, direct_alive, cam_alive}, 32'd0);
        chk("rst_resync", 32'(resync_timeout), 32'd0);
        rst = 1'b0;

        // Direct forwarding straight out of reset.
        drv(1, 8'h47, 1, 0, 8'h00, 0); expect_out(8'h47, 1); step();
        drv(1, 8'h01, 0, 0, 8'h00, 0); expect_out(8'h01, 0); step();
        drv(1, 8'h02, 0, 0, 8'h00, 0); expect_out(8'h02, 0); step();
        drv(0, 8'h00, 0, 0, 8'h00, 0); step();
        chk("t1_active_src", 32'(active_src), 32'd1);
        chk("t1_switching", 32'(switching), 32'd0);
        chk("t1_direct_alive", 32'(direct_alive), 32'd1);

        // Switch to CAM mid-packet; CAM bytes before its sync must not leak.
        cam_ready = 1'b1;
        drv(1, 8'h47, 1, 1, 8'h90, 0); expect_out(8'h47, 1); step();
        drv(1, 8'h0A, 0, 1, 8'h91, 0); expect_out(8'h0A, 0); step();
        drv(1, 8'h0B, 0, 1, 8'h92, 0); expect_out(8'h0B, 0); step();
        chk("t2_cam_alive", 32'(cam_alive), 32'd1);
        cam_bypass = 1'b0;
        drv(0, 8'h00, 0, 1, 8'h93, 0); step();
        chk("t2_switching", 32'(switching), 32'd1);
        chk("t2_active_hold", 32'(active_src), 32'd1);
        drv(1, 8'h0C, 0, 1, 8'h94, 0); step();
        drv(1, 8'h0D, 0, 1, 8'h95, 0); step();
        chk("t2_still_switching", 32'(switching), 32'd1);
        drv(1, 8'h0E, 0, 1, 8'h47, 1); expect_out(8'h47, 1); step();
        chk("t2_active_cam", 32'(active_src), 32'd0);
        chk("t2_switch_done", 32'(switching), 32'd0);

        // CAM goes silent: fallback to direct after 16 idle cycles.
        drv(0, 8'h00, 0, 1, 8'h12, 0); expect_out(8'h12, 0); step();
        drv(0, 8'h00, 0, 0, 8'h00, 0);
        repeat (15) step();
        chk("t3_cam_alive_15", 32'(cam_alive), 32'd1);
        step();
        chk("t3_cam_alive_16", 32'(cam_alive), 32'd0);
        chk("t3_not_yet_switching", 32'(switching), 32'd0);
        step();
        chk("t3_switching", 32'(switching), 32'd1);
        drv(1, 8'h47, 1, 0, 8'h00, 0); expect_out(8'h47, 1); step();
        drv(1, 8'h05, 0, 0, 8'h00, 0); expect_out(8'h05, 0); step();
        chk("t3_active_direct", 32'(active_src), 32'd1);

        // CAM revives but never sends sync: resync timeout after 16 cycles.
        drv(0, 8'h00, 0, 1, 8'h55, 0); step();
        drv(0, 8'h00, 0, 1, 8'h56, 0); step();
        chk("t4_switching", 32'(switching), 32'd1);
        chk("t4_resync_0", 32'(resync_timeout), 32'd0);
        repeat (15) step();
        chk("t4_resync_15", 32'(resync_timeout), 32'd0);
        step();
        chk("t4_resync_16", 32'(resync_timeout), 32'd1);
        repeat (3) step();
        chk("t4_resync_hold", 32'(resync_timeout), 32'd1);
        chk("t4_switching_hold", 32'(switching), 32'd1);
        drv(0, 8'h00, 0, 1, 8'h47, 1); expect_out(8'h47, 1); step();
        chk("t4_resync_clear", 32'(resync_timeout), 32'd0);
        chk("t4_active_cam", 32'(active_src), 32'd0);
        drv(0, 8'h00, 0, 1, 8'h60, 0); expect_out(8'h60, 0); step();

        // Simultaneous sync bytes with direct as target: only direct passes.
        cam_bypass = 1'b1;
        drv(0, 8'h00, 0, 1, 8'h61, 0); step();
        chk("t5_switching", 32'(switching), 32'd1);
        chk("t5_active_hold", 32'(active_src), 32'd0);
        drv(1, 8'h47, 1, 1, 8'hC7, 1); expect_out(8'h47, 1); step();
        drv(1, 8'h21, 0, 1, 8'h22, 0); expect_out(8'h21, 0); step();
        chk("t5_active_direct", 32'(active_src), 32'd1);

        // One-cycle reset mid-packet.
        drv(1, 8'h47, 1, 0, 8'h00, 0); expect_out(8'h47, 1); step();
        drv(1, 8'h30, 0, 0, 8'h00, 0); expect_out(8'h30, 0); step();
        drv(1, 8'h31, 0, 0, 8'h00, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_data", 32'(out_data), 32'd0);
        chk("t6_out_sync", 32'(out_sync), 32'd0);
        chk("t6_switching", 32'(switching), 32'd1);
        chk("t6_alive", {30'd0, direct_alive, cam_alive}, 32'd0);
        step();
        rst = 1'b0;
        drv(1, 8'h32, 0, 0, 8'h00, 0); step();
        drv(1, 8'h33, 0, 0, 8'h00, 0); step();
        drv(1, 8'h47, 1, 0, 8'h00, 0); expect_out(8'h47, 1); step();
        drv(1, 8'h34, 0, 0, 8'h00, 0); expect_out(8'h34, 0); step();
        drv(0, 8'h00, 0, 0, 8'h00, 0);
        repeat (3) step();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
